// File: rtl/arb_requester.sv
// Client-side requester for a round-robin arbiter: queues jobs, requests the bus,
// streams one beat per granted cycle, and releases req for one cycle between jobs.
module arb_requester #(
    parameter int DEPTH   = 4,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 3,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             res,
    input  logic             job_valid,
    input  logic [LEN_W-1:0] job_len,
    output logic             job_ready,
    output logic             req,
    input  logic             grant,
    output logic             beat,
    output logic             last,
    output logic             busy,
    output logic             starve,
    output logic [CNT_W-1:0] pending_cnt
);

    // state | meaning
    // IDLE  | no active job, req low
    // REQ   | job loaded, req high, waiting for first grant
    // XFER  | streaming beats on granted cycles
    // REL   | one-cycle req drop so the arbiter can rotate
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER, S_REL} state_t;

    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WAIT_W = 8;

    state_t             state_q, state_d;
    logic [LEN_W:0]     rem_q, rem_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic               req_q, req_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LEN_W-1:0]   fifo_q [DEPTH];

    logic               push;
    logic               pop;
    logic [LEN_W-1:0]   head_len;
    logic [LEN_W:0]     load_len;

    assign job_ready   = (count_q < CNT_W'(DEPTH));
    assign push        = job_valid && job_ready;
    assign pop         = ((state_q == S_IDLE) || (state_q == S_REL)) && (count_q != '0);
    assign head_len    = fifo_q[rd_ptr_q];
    // A zero length field means the full 2^LEN_W beats.
    assign load_len    = {(head_len == '0), head_len};

    assign req         = req_q;
    assign beat        = (state_q == S_XFER) && grant;
    assign last        = beat && (rem_q == (LEN_W+1)'(1));
    assign busy        = (state_q != S_IDLE);
    assign starve      = (wait_q == WAIT_W'(TIMEOUT));
    assign pending_cnt = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push)
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH-1)) ? '0 : wr_ptr_q + PTR_W'(1);
        if (pop)
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH-1)) ? '0 : rd_ptr_q + PTR_W'(1);
        if (push && !pop)
            count_d = count_q + CNT_W'(1);
        else if (pop && !push)
            count_d = count_q - CNT_W'(1);
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        case (state_q)
            S_IDLE, S_REL: begin
                state_d = S_IDLE;
                if (pop) begin
                    rem_d   = load_len;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (grant)
                    state_d = S_XFER;
            end
            S_XFER: begin
                if (beat) begin
                    rem_d = rem_q - (LEN_W+1)'(1);
                    if (last)
                        state_d = S_REL;
                end
            end
            default: state_d = S_IDLE;
        endcase

        wait_d = wait_q;
        if (grant || (state_d == S_IDLE) || (state_d == S_REL))
            wait_d = '0;
        else if (((state_q == S_REQ) || (state_q == S_XFER)) && (wait_q != WAIT_W'(TIMEOUT)))
            wait_d = wait_q + WAIT_W'(1);

        req_d = (state_d == S_REQ) || (state_d == S_XFER);
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q  <= S_IDLE;
            rem_q    <= '0;
            wait_q   <= '0;
            req_q    <= 1'b0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            wait_q   <= wait_d;
            req_q    <= req_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Payload storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push)
            fifo_q[wr_ptr_q] <= job_len;
    end

endmodule

// File: tb/tb_arb_requester.sv
// Randomized bench for arb_requester against a job-queue level reference model.
module tb_arb_requester;

    localparam int DEPTH   = 4;
    localparam int LEN_W   = 4;
    localparam int CNT_W   = 3;
    localparam int TIMEOUT = 16;

    logic             clk = 1'b0;
    logic             res;
    logic             job_valid;
    logic [LEN_W-1:0] job_len;
    logic             job_ready;
    logic             req;
    logic             grant;
    logic             beat;
    logic             last;
    logic             busy;
    logic             starve;
    logic [CNT_W-1:0] pending_cnt;

    arb_requester #(.DEPTH(DEPTH), .LEN_W(LEN_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .res(res), .job_valid(job_valid), .job_len(job_len),
        .job_ready(job_ready), .req(req), .grant(grant), .beat(beat), .last(last),
        .busy(busy), .starve(starve), .pending_cnt(pending_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference: pending lengths in a queue, the active job as beats left.
    int m_q[$];
    int m_rem;
    bit m_started;
    bit m_gap;
    int m_wait;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_rem = 0;
        m_started = 0;
        m_gap = 0;
        m_wait = 0;
    endtask

    task automatic check_outputs();
        bit exp_beat;
        exp_beat = (m_rem > 0) && m_started && grant;
        check_val("req",         int'(req),         int'(m_rem > 0));
        check_val("beat",        int'(beat),        int'(exp_beat));
        check_val("last",        int'(last),        int'(exp_beat && m_rem == 1));
        check_val("busy",        int'(busy),        int'((m_rem > 0) || m_gap));
        check_val("starve",      int'(starve),      int'(m_wait == TIMEOUT));
        check_val("job_ready",   int'(job_ready),   int'(m_q.size() < DEPTH));
        check_val("pending_cnt", int'(pending_cnt), m_q.size());
    endtask

    task automatic model_step(input bit v, input int len, input bit g);
        bit push;
        bit beat_e;
        push   = v && (m_q.size() < DEPTH);
        beat_e = (m_rem > 0) && m_started && g;
        if (m_rem == 0) begin
            m_gap  = 0;
            m_wait = 0;
            if (m_q.size() > 0) begin
                m_rem = m_q.pop_front();
                m_started = 0;
            end
        end else if (beat_e) begin
            m_rem--;
            m_wait = 0;
            if (m_rem == 0) begin
                m_gap = 1;
                m_started = 0;
            end
        end else if (g) begin
            m_started = 1;
            m_wait = 0;
        end else if (m_wait < TIMEOUT) begin
            m_wait++;
        end
        if (push)
            m_q.push_back((len == 0) ? (1 << LEN_W) : len);
    endtask

    // Called just after a rising edge; returns just after the next one.
    task automatic cycle(input bit v, input int len, input bit g);
        job_valid = v;
        job_len   = LEN_W'(len);
        grant     = g;
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_step(v, len, g);
        #1;
    endtask

    task automatic async_reset();
        res = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        #1;
        res = 1'b0;
    endtask

    task automatic rand_phase(input int cycles, input int valid_pct, input int grant_pct, input int zero_pct);
        int len;
        for (int i = 0; i < cycles; i++) begin
            len = ($urandom_range(99) < zero_pct) ? 0 : int'($urandom_range(15, 1));
            cycle($urandom_range(99) < valid_pct, len, $urandom_range(99) < grant_pct);
        end
    endtask

    initial begin
        res = 1'b1;
        job_valid = 1'b1;
        job_len = 4'd3;
        grant = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        #1;
        res = 1'b0;

        // Single len=3 job, grant returned one cycle after req.
        cycle(1, 3, 0);
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        for (int i = 0; i < 8; i++) cycle(0, 0, 1);

        // Overfill the FIFO while ungranted, then drain in order.
        for (int i = 0; i < 6; i++) cycle(1, i + 2, 0);
        for (int i = 0; i < 40; i++) cycle(0, 0, 1);

        // Grant gap mid-job.
        cycle(1, 4, 0);
        cycle(0, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 1);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 1);

        // Starvation: hold grant low past TIMEOUT, then release.
        cycle(1, 2, 0);
        for (int i = 0; i < TIMEOUT + 6; i++) cycle(0, 0, 0);
        for (int i = 0; i < 6; i++) cycle(0, 0, 1);

        // Zero length encodes 16 beats.
        cycle(1, 0, 0);
        for (int i = 0; i < 22; i++) cycle(0, 0, 1);

        // Reset mid-transfer with jobs queued.
        cycle(1, 8, 0);
        cycle(1, 5, 0);
        cycle(1, 6, 1);
        cycle(0, 0, 1);
        cycle(0, 0, 1);
        grant = 1'b1;
        async_reset();
        for (int i = 0; i < 5; i++) cycle(0, 0, 1);

        rand_phase(200, 30, 90, 10);
        rand_phase(200, 70, 40, 10);
        rand_phase(150, 50, 5, 5);
        rand_phase(100, 20, 100, 20);
        for (int i = 0; i < 60; i++) cycle(0, 0, 0);
        rand_phase(100, 60, 60, 10);
        async_reset();
        rand_phase(200, 40, 70, 15);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
